fifo_uart_tx: RTL
=================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, meaning serial bit rate.
REQ-003 SHALL derive localparam BAUD_DIV = CLK_HZ/BAUD (10416 at defaults), meaning clocks per serial bit; BAUD_DIV >= 2.
REQ-004 SHALL have port iClk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port iRst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port iEmpty  input  1  FIFO empty flag from the upstream FIFO.
REQ-007 SHALL have port oPop  output  1  single-cycle pop request to the FIFO.
REQ-008 SHALL have port iRdData  input  8  FIFO read data, valid exactly one cycle after oPop.
REQ-009 SHALL have port oTx  output  1  serial line, idle high.
REQ-010 SHALL have port oBusy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, POP, LOAD, START, DATA, PARITY, STOP.
REQ-012 IDLE: iEmpty=0 -> next state POP; iEmpty=1 -> remain IDLE; oTx=1.
REQ-013 POP: oPop=1 for exactly this one cycle; unconditional -> LOAD; oPop SHALL be 0 in every other state.
REQ-014 LOAD: capture iRdData into 8-bit shift register, clear baud counter and bit index -> START.
REQ-015 START: oTx=0 for BAUD_DIV cycles -> DATA.
REQ-016 DATA: oTx=shift[0], LSB first; every BAUD_DIV cycles shift right, bit index +1; after 8th bit -> PARITY if enabled (REQ-025) else STOP.
REQ-017 STOP: oTx=1 for BAUD_DIV cycles; at final cycle iEmpty=0 -> POP (back-to-back, no extra idle cycle beyond POP/LOAD), iEmpty=1 -> IDLE.
REQ-018 Baud counter: width $clog2(BAUD_DIV), counts 0..BAUD_DIV-1, wraps to 0 and issues bit tick on BAUD_DIV-1; cleared on every state entry.
REQ-019 oTx SHALL be driven from a register (glitch-free); frame period = (10 or 11)*BAUD_DIV cycles plus 2 overhead cycles (POP, LOAD).
REQ-020 iEmpty changes during START/DATA/PARITY/STOP SHALL be ignored until end of STOP.
REQ-021 oPop SHALL never assert while iEmpty=1 at the IDLE/STOP decision cycle; no second pop before current frame ends.
REQ-022 A pop SHALL always consume exactly one byte; no byte dropped or duplicated.

Reset
REQ-023 iRst=1 at any rising edge SHALL force: state IDLE, oTx=1, oPop=0, oBusy=0, baud counter 0, bit index 0, shift register 8'h00.
REQ-024 Reset mid-frame SHALL abort the frame immediately (line returns high next cycle); the aborted byte is lost, not re-popped.

Configuration
REQ-025 Macro FIFO_UART_TX_PARITY_EN defined: PARITY state present, oTx = XOR of the 8 data bits (even parity) for BAUD_DIV cycles between DATA and STOP; frame 11 bits.
REQ-026 Macro FIFO_UART_TX_PARITY_EN undefined: PARITY state unreachable and removed, DATA -> STOP directly; frame 10 bits.

Structure
REQ-027 Package fifo_uart_pkg SHALL hold the FSM state enum typedef, DATA_W=8, and STOP/START line-level constants.
REQ-028 Sub-module baud_tick_gen SHALL hold the baud counter (inputs iClk, iRst, iClr; output oTick), parameter BAUD_DIV.
REQ-029 No other sub-modules; fifo_uart_tx SHALL connect directly to the existing FIFO's iPop/oRdData/oEmpty.

Verification (bench: CLK_HZ=40, BAUD=10 -> BAUD_DIV=4, model FIFO with 1-cycle read latency)
REQ-030 Reset, FIFO empty 50 cycles -> oTx=1, oPop=0, oBusy=0 throughout.
REQ-031 Push 8'hA5 -> oPop pulses one cycle, then oTx: 0 (4 clk), bits 1,0,1,0,0,1,0,1 (4 clk each), 1 (4 clk); oBusy high 42 cycles (46 with parity).
REQ-032 Push 8'h00, 8'hFF, 8'h3C back-to-back -> three frames decoded in order, exactly 2 cycles of high between STOP end and next START, exactly 3 pops.
REQ-033 Parity build, send 8'h07 -> parity bit 1; send 8'h03 -> parity bit 0.
REQ-034 Assert iRst in the 5th data bit of 8'h55 -> oTx=1 next cycle, oBusy=0, FIFO level unchanged after reset (no re-pop).
REQ-035 Fill FIFO to full (16 entries), run to drain -> 16 frames in write order, iEmpty=1 at end, no oPop while iEmpty=1.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for fifo_uart_tx.
// Defining FIFO_UART_TX_PARITY_EN adds the PARITY state (even parity bit).
package fifo_uart_pkg;

    localparam int   DATA_W     = 8;
    localparam int   IDX_W      = $clog2(DATA_W);
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_LOAD,
        ST_START,
        ST_DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } tx_state_t;

    function automatic logic even_parity(input logic [DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Baud counter for fifo_uart_tx: counts 0..BAUD_DIV-1 and flags the last count.
// Cleared on every FSM state entry so each state starts a fresh bit period.
module baud_tick_gen #(
    parameter int BAUD_DIV = 4
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iClr,
    output logic oTick
);
    localparam int                CNT_W    = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge iClk) begin
        if (iRst || iClr) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign oTick = (cnt == CNT_LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from an upstream FIFO (1-cycle read latency) and
// sends 8N1 frames; FIFO_UART_TX_PARITY_EN inserts an even parity bit before STOP.
//
//   state  | meaning
//   IDLE   | line high, waiting for FIFO not empty
//   POP    | one-cycle pop request
//   LOAD   | FIFO data valid, capture into shift register
//   START  | start bit
//   DATA   | 8 data bits, LSB first
//   PARITY | even parity bit (parity build only)
//   STOP   | stop bit, then next byte or IDLE
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iEmpty,
    output logic              oPop,
    input  logic [DATA_W-1:0] iRdData,
    output logic              oTx,
    output logic              oBusy
);
    localparam int BAUD_DIV = CLK_HZ / BAUD;

    tx_state_t         state, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  bit_idx, bit_idx_d;
    logic              tx_q, tx_d;
    logic              tick;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    baud_tick_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .iClk  (iClk),
        .iRst  (iRst),
        .iClr  (state_d != state),
        .oTick (tick)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= ST_IDLE;
            shift_q <= '0;
            bit_idx <= '0;
            tx_q    <= LINE_STOP;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            shift_q <= shift_d;
            bit_idx <= bit_idx_d;
            tx_q    <= tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d   = state;
        shift_d   = shift_q;
        bit_idx_d = bit_idx;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state)
            ST_IDLE:  if (!iEmpty) state_d = ST_POP;
            ST_POP:   state_d = ST_LOAD;
            ST_LOAD: begin
                shift_d   = iRdData;
                bit_idx_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_d  = even_parity(iRdData);
`endif
                state_d   = ST_START;
            end
            ST_START: if (tick) state_d = ST_DATA;
            ST_DATA: begin
                if (tick) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx + 1'b1;
                    if (bit_idx == IDX_W'(DATA_W - 1)) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: if (tick) state_d = ST_STOP;
`endif
            // FIFO level is only looked at here, on the last stop-bit cycle
            ST_STOP:  if (tick) state_d = iEmpty ? ST_IDLE : ST_POP;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Line level is computed from the next state so the register changes with the state
    always_comb begin
        oPop  = (state == ST_POP);
        oBusy = (state != ST_IDLE);
        case (state_d)
            ST_START:  tx_d = LINE_START;
            ST_DATA:   tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            default:   tx_d = LINE_STOP;
        endcase
    end

    assign oTx = tx_q;

endmodule
